// File: rtl/demux_8_1x8_buf.sv
// Registered 1-to-8 bus demultiplexer: one valid/ready input steered by a 3-bit select
// into eight single-entry output slots, each draining through its own valid/ready port.
module demux_8_1x8_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic [2:0]           in_sel_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [8*WIDTH-1:0]   out_data_o,
  output logic [7:0]           out_valid_o,
  input  logic [7:0]           out_ready_i,
  output logic [3:0]           occupancy_o
);

  logic [7:0]       v_q, v_d;
  logic [WIDTH-1:0] d_q [8];
  logic [WIDTH-1:0] d_d [8];
  logic [3:0]       occ_q, occ_d;
  logic             accept;

  // A full slot can still accept when its consumer drains it on the same edge.
  assign in_ready_o = rst_ni & ~flush_i & (~v_q[in_sel_i] | out_ready_i[in_sel_i]);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    v_d = v_q & ~out_ready_i;
    d_d = d_q;
    if (accept) begin
      v_d[in_sel_i] = 1'b1;
      d_d[in_sel_i] = in_data_i;
    end
    // Flush drops every held word; handshakes seen during the flush cycle are void.
    if (flush_i) begin
      v_d = '0;
    end
    occ_d = '0;
    for (int k = 0; k < 8; k++) begin
      occ_d = occ_d + {3'b000, v_d[k]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < 8; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_out
    assign out_data_o[k*WIDTH +: WIDTH] = d_q[k];
  end

  assign out_valid_o = v_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_demux_8_1x8_buf.sv
// Self-checking bench for demux_8_1x8_buf: directed scenarios plus randomized traffic
// checked against a slot-array reference model.
module tb_demux_8_1x8_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [3:0]  occupancy;

  int vecs = 0;
  int errs = 0;

  // Reference model: per-channel full flag and held word.
  bit       mv [8];
  bit [7:0] md [8];

  always #5 clk = ~clk;

  demux_8_1x8_buf #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .occupancy_o (occupancy)
  );

  function automatic logic [7:0] m_valid();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = mv[k];
    return r;
  endfunction

  function automatic logic [63:0] m_data();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = md[k];
    return r;
  endfunction

  function automatic logic [3:0] m_occ();
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(mv[k]);
    return 4'(n);
  endfunction

  function automatic logic m_ready();
    return !flush && (!mv[in_sel] || out_ready[in_sel]);
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < 8; k++) begin
      mv[k] = 1'b0;
      md[k] = 8'h00;
    end
  endfunction

  task automatic apply(input logic v, input logic [2:0] s, input logic [7:0] dat,
                       input logic [7:0] rdy, input logic f);
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = dat;
    out_ready = rdy;
    flush     = f;
    #1;
  endtask

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    bit acc;
    acc = in_valid && m_ready();
    if (flush) begin
      for (int k = 0; k < 8; k++) mv[k] = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) if (mv[k] && out_ready[k]) mv[k] = 1'b0;
      if (acc) begin
        mv[in_sel] = 1'b1;
        md[in_sel] = in_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 8'h00; flush = 1'b0;
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vecs++;
    if (out_valid !== 8'h00) begin errs++; $display("FAIL reset_valid got %h want 00", out_valid); end
    vecs++;
    if (occupancy !== 4'd0) begin errs++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    vecs++;
    if (out_data !== 64'h0) begin errs++; $display("FAIL reset_data got %h want 0", out_data); end
  endtask

  task automatic test_single();
    apply(1'b1, 3'd5, 8'hA5, 8'h00, 1'b0);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL single_ready got %b want 1", in_ready); end
    tick();
    vecs++;
    if (out_valid !== 8'h20) begin errs++; $display("FAIL single_valid got %h want 20", out_valid); end
    vecs++;
    if (out_data[47:40] !== 8'hA5) begin
      errs++; $display("FAIL single_data got %h want a5", out_data[47:40]);
    end
    vecs++;
    if (occupancy !== 4'd1) begin errs++; $display("FAIL single_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_stall();
    do_reset();
    apply(1'b1, 3'd2, 8'h5A, 8'h00, 1'b0);
    tick();
    apply(1'b1, 3'd2, 8'h11, 8'h00, 1'b0);
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_ready got %b want 0", in_ready); end
    tick();
    vecs++;
    if (out_data[23:16] !== 8'h5A) begin
      errs++; $display("FAIL stall_keep got %h want 5a", out_data[23:16]);
    end
    apply(1'b1, 3'd3, 8'h33, 8'h00, 1'b0);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_other_ready got %b want 1", in_ready); end
    tick();
    vecs++;
    if (out_valid !== 8'h0C) begin errs++; $display("FAIL stall_valid got %h want 0c", out_valid); end
    vecs++;
    if (occupancy !== 4'd2) begin errs++; $display("FAIL stall_occ got %0d want 2", occupancy); end
  endtask

  task automatic test_drain_load();
    do_reset();
    apply(1'b1, 3'd2, 8'h11, 8'h00, 1'b0);
    tick();
    apply(1'b1, 3'd2, 8'h22, 8'h04, 1'b0);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL dl_ready got %b want 1", in_ready); end
    vecs++;
    if (out_data[23:16] !== 8'h11 || out_valid[2] !== 1'b1) begin
      errs++; $display("FAIL dl_old got %h/%b want 11/1", out_data[23:16], out_valid[2]);
    end
    tick();
    vecs++;
    if (out_data[23:16] !== 8'h22) begin errs++; $display("FAIL dl_new got %h want 22", out_data[23:16]); end
    vecs++;
    if (out_valid !== 8'h04 || occupancy !== 4'd1) begin
      errs++; $display("FAIL dl_state got %h/%0d want 04/1", out_valid, occupancy);
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 3'(i), 8'(8'h10 + i), 8'h00, 1'b0);
      tick();
    end
  endtask

  task automatic test_fill_all();
    do_reset();
    fill_all();
    vecs++;
    if (out_valid !== 8'hFF || occupancy !== 4'd8) begin
      errs++; $display("FAIL fill_state got %h/%0d want ff/8", out_valid, occupancy);
    end
    vecs++;
    if (out_data !== 64'h1716151413121110) begin
      errs++; $display("FAIL fill_data got %h want 1716151413121110", out_data);
    end
    for (int s = 0; s < 8; s++) begin
      apply(1'b0, 3'(s), 8'h00, 8'h00, 1'b0);
      vecs++;
      if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_ready sel %0d got %b want 0", s, in_ready); end
    end
    apply(1'b0, 3'd0, 8'h00, 8'hFF, 1'b0);
    tick();
    vecs++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
      errs++; $display("FAIL drain_all got %h/%0d want 00/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill_all();
    apply(1'b1, 3'd3, 8'hEE, 8'hFF, 1'b1);
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick();
    vecs++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
      errs++; $display("FAIL flush_state got %h/%0d want 00/0", out_valid, occupancy);
    end
    vecs++;
    if (out_data[31:24] !== 8'h13) begin
      errs++; $display("FAIL flush_data got %h want 13", out_data[31:24]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'(i), 8'($urandom_range(1, 255)), 8'h00, 1'b0);
      tick();
    end
    vecs++;
    if (occupancy !== 4'd3) begin errs++; $display("FAIL ar_pre_occ got %0d want 3", occupancy); end
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0 || out_data !== 64'h0 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL ar_clear got v=%h occ=%0d d=%h rdy=%b want all 0",
               out_valid, occupancy, out_data, in_ready);
    end
    m_clear();
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 3'd6; in_data = 8'hC3; out_ready = 8'h00; flush = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL ar_ready got %b want 1", in_ready); end
    tick();
    vecs++;
    if (out_valid !== 8'h40 || out_data[55:48] !== 8'hC3 || occupancy !== 4'd1) begin
      errs++;
      $display("FAIL ar_resume got %h/%h/%0d want 40/c3/1", out_valid, out_data[55:48], occupancy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom & $urandom),
            ($urandom_range(0, 15) == 0));
      vecs++;
      if (in_ready !== m_ready()) begin
        errs++; $display("FAIL rnd_ready iter %0d got %b want %b", i, in_ready, m_ready());
      end
      tick();
      vecs++;
      if (out_valid !== m_valid() || occupancy !== m_occ() || out_data !== m_data()) begin
        errs++;
        $display("FAIL rnd_state iter %0d got v=%h occ=%0d d=%h want v=%h occ=%0d d=%h",
                 i, out_valid, occupancy, out_data, m_valid(), m_occ(), m_data());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 8'h00; flush = 1'b0;
    m_clear();
    test_reset();
    test_single();
    test_stall();
    test_drain_load();
    test_fill_all();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
